// File: rtl/actel_s2_cfg_loader_if.sv
// Serial config stream in, parallel S2 cell configuration words out.
interface actel_s2_cfg_loader_if #(parameter int NUM_CELLS = 2);
  localparam int TOTAL = NUM_CELLS * 8;

  logic             start;
  logic             sdi;
  logic             sdi_valid;
  logic             busy;
  logic             done;
  logic [TOTAL-1:0] cfg_out;
  logic             cfg_valid;
  logic             cell_clr_n;
  logic             err;

  modport master (output start, sdi, sdi_valid,
                  input  busy, done, cfg_out, cfg_valid, cell_clr_n, err);
  modport slave  (input  start, sdi, sdi_valid,
                  output busy, done, cfg_out, cfg_valid, cell_clr_n, err);
endinterface

// File: rtl/actel_s2_cfg_loader.sv
// Serial loader for NUM_CELLS Actel S2 cell config words; holds the cells cleared while loading.
// Optional trailing even-parity check enabled by `define CFG_PARITY_EN.
module actel_s2_cfg_loader #(
  parameter int NUM_CELLS = 2
) (
  input logic                  CLK,
  input logic                  CLR,
  actel_s2_cfg_loader_if.slave bus
);
  localparam int TOTAL = NUM_CELLS * 8;
`ifdef CFG_PARITY_EN
  localparam int NBITS = TOTAL + 1;
`else
  localparam int NBITS = TOTAL;
`endif
  localparam int CW = $clog2(TOTAL + 2);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK, APPLY} state_t;

  state_t                    state;
  logic [CW-1:0]             cnt;
  logic [TOTAL-1:0]          shadow;
  logic [NUM_CELLS-1:0][7:0] cfg_q;
  logic                      busy_q, done_q, valid_q, clr_n_q;
`ifdef CFG_PARITY_EN
  logic                      par_q, pass_q, err_q;
`endif

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state   <= IDLE;
      cnt     <= '0;
      shadow  <= '0;
      cfg_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      clr_n_q <= 1'b0;
`ifdef CFG_PARITY_EN
      par_q   <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state   <= SHIFT;
            cnt     <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b1;
            clr_n_q <= 1'b0;
`ifdef CFG_PARITY_EN
            par_q   <= 1'b0;
            err_q   <= 1'b0;
`endif
          end else begin
            clr_n_q <= 1'b1;
          end
        end
        SHIFT: begin
          if (bus.sdi_valid) begin
            cnt <= cnt + CW'(1);
`ifdef CFG_PARITY_EN
            par_q <= par_q ^ bus.sdi;
            // trailing parity bit is counted but never enters the shadow
            if (cnt != CW'(TOTAL)) shadow <= {shadow[TOTAL-2:0], bus.sdi};
`else
            shadow <= {shadow[TOTAL-2:0], bus.sdi};
`endif
            if (cnt == CW'(NBITS - 1)) state <= CHECK;
          end
        end
        CHECK: begin
`ifdef CFG_PARITY_EN
          pass_q <= ~par_q;
`endif
          state <= APPLY;
        end
        APPLY: begin
          state   <= IDLE;
          busy_q  <= 1'b0;
          clr_n_q <= 1'b1;
          done_q  <= 1'b1;
`ifdef CFG_PARITY_EN
          if (pass_q) begin
            cfg_q   <= shadow;
            valid_q <= 1'b1;
          end else begin
            err_q   <= 1'b1;
          end
`else
          cfg_q   <= shadow;
          valid_q <= 1'b1;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.cfg_out    = cfg_q;
  assign bus.cfg_valid  = valid_q;
  assign bus.cell_clr_n = clr_n_q;
`ifdef CFG_PARITY_EN
  assign bus.err        = err_q;
`else
  assign bus.err        = 1'b0;
`endif
endmodule

// File: tb/tb_actel_s2_cfg_loader.sv
// Randomized bench for actel_s2_cfg_loader against a bit-queue / edge-count reference model.
module tb_actel_s2_cfg_loader;
  localparam int NUM_CELLS = 2;
  localparam int TOTAL = NUM_CELLS * 8;
`ifdef CFG_PARITY_EN
  localparam int NB = TOTAL + 1;
  localparam bit PAR = 1'b1;
`else
  localparam int NB = TOTAL;
  localparam bit PAR = 1'b0;
`endif

  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  actel_s2_cfg_loader_if #(.NUM_CELLS(NUM_CELLS)) bus ();
  actel_s2_cfg_loader #(.NUM_CELLS(NUM_CELLS)) dut (.CLK(clk), .CLR(clr), .bus(bus.slave));

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: collect accepted bits in a queue; the result lands two edges after the last bit.
  bit               m_loading;
  bit               q[$];
  int               cyc, apply_edge;
  bit               m_pass;
  logic [TOTAL-1:0] m_data;
  logic [TOTAL-1:0] exp_cfg;
  bit exp_valid, exp_err, exp_done, exp_busy, exp_clrn;

  always @(posedge clk or negedge clr) begin
    if (!clr) begin
      m_loading = 0; q.delete(); cyc = 0; apply_edge = -10;
      exp_cfg = '0; exp_valid = 0; exp_err = 0; exp_done = 0; exp_busy = 0; exp_clrn = 0;
    end else begin
      cyc++;
      exp_done = 0;
      if (m_loading) begin
        if (bus.sdi_valid) begin
          q.push_back(bus.sdi);
          if (q.size() == NB) begin
            bit x;
            x = 0;
            foreach (q[i]) x ^= q[i];
            for (int i = 0; i < TOTAL; i++) m_data[TOTAL-1-i] = q[i];
            m_pass = PAR ? (x == 1'b0) : 1'b1;
            m_loading = 0;
            apply_edge = cyc + 2;
          end
        end
      end else if (cyc > apply_edge) begin
        if (bus.start) begin
          m_loading = 1; q.delete();
          exp_err = 0; exp_valid = 0; exp_busy = 1; exp_clrn = 0;
        end else begin
          exp_clrn = 1;
        end
      end
      if (cyc == apply_edge) begin
        exp_done = 1; exp_busy = 0; exp_clrn = 1;
        if (m_pass) begin exp_cfg = m_data; exp_valid = 1; end
        else exp_err = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cfg_out",    bus.cfg_out,    exp_cfg);
      chk("cfg_valid",  bus.cfg_valid,  exp_valid);
      chk("done",       bus.done,       exp_done);
      chk("busy",       bus.busy,       exp_busy);
      chk("cell_clr_n", bus.cell_clr_n, exp_clrn);
      chk("err",        bus.err,        exp_err);
    end
  end

  // mode: 0 continuous, 1 alternating valid, 2 random valid; start_at re-pulses start mid-stream
  task automatic do_load(input logic [TOTAL-1:0] v, input int mode, input bit bad_par,
                         input int start_at, input bit sync);
    int  i;
    bit  vld, tog;
    logic p, b;
    p = (^v) ^ bad_par;
    if (sync) @(negedge clk);
    bus.start = 1; bus.sdi_valid = 0;
    @(negedge clk);
    bus.start = 0;
    i = 0; tog = 1;
    while (i < NB) begin
      bus.start = (i == start_at);
      b = (i < TOTAL) ? v[TOTAL-1-i] : p;
      case (mode)
        0:       vld = 1;
        1:       begin vld = tog; tog = ~tog; end
        default: vld = $urandom_range(0, 1);
      endcase
      if (vld) begin bus.sdi = b; bus.sdi_valid = 1; i++; end
      else begin bus.sdi = 1'($urandom); bus.sdi_valid = 0; end
      @(negedge clk);
    end
    bus.start = 0; bus.sdi_valid = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 0; bus.sdi = 0; bus.sdi_valid = 0;
    // reset / idle
    @(negedge clk); #2 clr = 0;
    cmp_en = 1;
    @(negedge clk);
    chk("rst_cfg_out", bus.cfg_out, 16'h0000);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_clr_n", bus.cell_clr_n, 1'b0);
    chk("rst_valid", bus.cfg_valid, 1'b0);
    #2 clr = 1;
    @(negedge clk);
    chk("rel_clr_n", bus.cell_clr_n, 1'b1);
    chk("rel_busy", bus.busy, 1'b0);

    // basic load
    do_load(16'h6A5C, 0, 0, -1, 1);
    @(negedge clk);
    chk("basic_no_early_done", bus.done, 1'b0);
    @(negedge clk);
    chk("basic_done", bus.done, 1'b1);
    chk("basic_cfg", bus.cfg_out, 16'h6A5C);
    chk("basic_cell0", bus.cfg_out[7:0], 8'h5C);
    chk("basic_valid", bus.cfg_valid, 1'b1);
    chk("basic_clr_n", bus.cell_clr_n, 1'b1);

    // start accepted in the done cycle, stalled stream
    do_load(16'h6A5C, 1, 0, -1, 0);
    repeat (2) @(negedge clk);
    chk("stall_done", bus.done, 1'b1);
    chk("stall_cfg", bus.cfg_out, 16'h6A5C);

`ifdef CFG_PARITY_EN
    do_load(16'hFFFF, 0, 1, -1, 1);
    repeat (2) @(negedge clk);
    chk("par_err", bus.err, 1'b1);
    chk("par_valid", bus.cfg_valid, 1'b0);
    chk("par_cfg_kept", bus.cfg_out, 16'h6A5C);
    chk("par_done", bus.done, 1'b1);
`else
    chk("noparity_err", bus.err, 1'b0);
`endif

    // abort after 7 bits
    @(negedge clk); bus.start = 1;
    @(negedge clk); bus.start = 0;
    for (int i = 0; i < 7; i++) begin
      bus.sdi = 1'($urandom); bus.sdi_valid = 1;
      @(negedge clk);
    end
    bus.sdi_valid = 0;
    #2 clr = 0;
    @(negedge clk);
    chk("abort_cfg", bus.cfg_out, 16'h0000);
    chk("abort_busy", bus.busy, 1'b0);
    #2 clr = 1;
    do_load(16'hC3A1, 2, 0, -1, 1);
    repeat (2) @(negedge clk);
    chk("abort_reload", bus.cfg_out, 16'hC3A1);

    // ignored start during SHIFT
    do_load(16'h1E78, 0, 0, 5, 1);
    repeat (2) @(negedge clk);
    chk("ign_start_cfg", bus.cfg_out, 16'h1E78);
    chk("ign_start_valid", bus.cfg_valid, 1'b1);

    // randomized loads
    for (int n = 0; n < 30; n++) begin
      logic [TOTAL-1:0] v;
      int sa;
      bit bad;
      v = TOTAL'($urandom);
      bad = PAR && ($urandom_range(0, 3) == 0);
      sa = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, NB - 1)) : -1;
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        bus.sdi = 1'($urandom); bus.sdi_valid = 1'($urandom);
      end
      do_load(v, $urandom_range(0, 2), bad, sa, 1);
      repeat (2) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    cmp_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
